phys_free_list: RTL and testbench

- Circular FIFO of free physical register tags that feeds the rename stage.
- Rename dequeues one tag per renamed destination (register write or load); the RRAT enqueues one tag per retired overwritten mapping.
- On FLUSH the list is rebuilt from the committed RRAT map with a sequential scan.
- While empty or rebuilding, it raises halt, which rename ORs into its stall.

---
 rtl/free_list_pkg.sv | 16 +
 rtl/phys_free_list.sv | 136 +++++++++++++
 tb/tb_phys_free_list.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/free_list_pkg.sv
// Shared constants and types for the physical register free list.
package free_list_pkg;

    localparam int NUM_PREGS = 64;
    localparam int NUM_AREGS = 32;
    localparam int TAG_W     = $clog2(NUM_PREGS);
    localparam int NUM_FREE  = NUM_PREGS - NUM_AREGS;

    typedef logic [TAG_W-1:0] tag_t;

    typedef enum logic {
        FL_RUN,
        FL_REBUILD
    } fl_state_t;

endpackage

// File: rtl/phys_free_list.sv
// Circular free list of physical tags feeding rename.
// A flush rebuilds the list from the committed RRAT map, one tag per cycle.
module phys_free_list
    import free_list_pkg::*;
(
    input  logic           CLK,
    input  logic           RESET,
    input  logic           STALL,
    input  logic           FLUSH,
    input  logic           enque,
    input  tag_t           enque_data,
    input  logic           deque,
    output tag_t           deque_data,
    input  tag_t           r_mapping [NUM_AREGS],
    output logic           halt,
    output logic [TAG_W:0] count,
    output logic           overflow_err
);

    localparam logic [TAG_W:0] CAP  = (TAG_W+1)'(NUM_PREGS);
    localparam tag_t           LAST = tag_t'(NUM_PREGS - 1);

    fl_state_t state_q, state_d;

    tag_t           mem [NUM_PREGS];
    tag_t           head_q;
    tag_t           tail_q;
    tag_t           idx_q;
    logic [TAG_W:0] count_q;
    logic [NUM_PREGS-1:0] used_q;
    logic [NUM_PREGS-1:0] used_snap;
    logic           ovf_q;

    logic deq_fire;
    logic enq_fire;
    logic scan_push;
    logic ovf_set;
    logic wr_en;
    tag_t wr_data;

    always_comb begin
        used_snap = '0;
        for (int a = 0; a < NUM_AREGS; a++) begin
            used_snap[r_mapping[a]] = 1'b1;
        end
    end

    assign halt = (count_q == '0) | (state_q == FL_REBUILD);

    // Flush wins over both ports; rebuild ignores rename and RRAT traffic.
    always_comb begin
        state_d   = state_q;
        deq_fire  = 1'b0;
        enq_fire  = 1'b0;
        scan_push = 1'b0;
        ovf_set   = 1'b0;
        if (FLUSH) begin
            state_d = FL_REBUILD;
        end else begin
            unique case (state_q)
                FL_RUN: begin
                    deq_fire = deque & ~STALL & ~halt;
                    enq_fire = enque & (count_q != CAP);
                    ovf_set  = enque & (count_q == CAP);
                end
                FL_REBUILD: begin
                    scan_push = ~used_q[idx_q];
                    if (idx_q == LAST) begin
                        state_d = FL_RUN;
                    end
                end
                default: begin
                    state_d = FL_RUN;
                end
            endcase
        end
    end

    assign wr_en   = enq_fire | scan_push;
    assign wr_data = scan_push ? idx_q : enque_data;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= FL_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            head_q  <= '0;
            tail_q  <= tag_t'(NUM_FREE);
            count_q <= (TAG_W+1)'(NUM_FREE);
            idx_q   <= '0;
            used_q  <= '0;
            ovf_q   <= 1'b0;
        end else if (FLUSH) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
            used_q  <= used_snap;
        end else begin
            if (deq_fire) begin
                head_q <= head_q + 1'b1;
            end
            if (wr_en) begin
                tail_q <= tail_q + 1'b1;
            end
            count_q <= count_q + {{TAG_W{1'b0}}, wr_en}
                               - {{TAG_W{1'b0}}, deq_fire};
            if (state_q == FL_REBUILD) begin
                idx_q <= idx_q + 1'b1;
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                mem[i] <= (i < NUM_FREE) ? tag_t'(NUM_AREGS + i) : '0;
            end
        end else if (wr_en) begin
            mem[tail_q] <= wr_data;
        end
    end

    assign deque_data   = halt ? '0 : mem[head_q];
    assign count        = count_q;
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_phys_free_list.sv
// Bench for phys_free_list: queue-based model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_phys_free_list;
    import free_list_pkg::*;

    logic           CLK = 1'b0;
    logic           RESET = 1'b1;
    logic           STALL = 1'b0;
    logic           FLUSH = 1'b0;
    logic           enque = 1'b0;
    tag_t           enque_data = '0;
    logic           deque = 1'b0;
    tag_t           deque_data;
    tag_t           r_mapping [NUM_AREGS];
    logic           halt;
    logic [TAG_W:0] count;
    logic           overflow_err;

    int checks = 0;
    int failures = 0;

    phys_free_list dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .STALL        (STALL),
        .FLUSH        (FLUSH),
        .enque        (enque),
        .enque_data   (enque_data),
        .deque        (deque),
        .deque_data   (deque_data),
        .r_mapping    (r_mapping),
        .halt         (halt),
        .count        (count),
        .overflow_err (overflow_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: the list is a queue of tags; a rebuild is modelled as the
    // final ascending free list plus a count of cycles elapsed.
    int  q[$];
    int  pend[$];
    bit  rebuilding = 0;
    int  rb_cycles = 0;
    bit  movf = 0;
    bit  mvalid = 0;

    always @(posedge CLK) begin
        if (RESET) begin
            q = {};
            for (int i = 0; i < NUM_FREE; i++) q.push_back(NUM_AREGS + i);
            rebuilding = 0;
            movf = 0;
            mvalid = 1;
        end else if (FLUSH) begin
            bit present [NUM_PREGS];
            for (int t = 0; t < NUM_PREGS; t++) present[t] = 0;
            for (int a = 0; a < NUM_AREGS; a++) present[r_mapping[a]] = 1;
            pend = {};
            for (int t = 0; t < NUM_PREGS; t++) if (!present[t]) pend.push_back(t);
            q = {};
            rebuilding = 1;
            rb_cycles = 0;
        end else if (rebuilding) begin
            rb_cycles++;
            if (rb_cycles == NUM_PREGS) begin
                q = pend;
                rebuilding = 0;
            end
        end else begin
            bit empty;
            bit full;
            empty = (q.size() == 0);
            full  = (q.size() == NUM_PREGS);
            if (enque) begin
                if (full) movf = 1;
                else q.push_back(int'(enque_data));
            end
            if (deque && !STALL && !empty) void'(q.pop_front());
        end
    end

    function automatic int exp_count();
        int n;
        n = 0;
        if (!rebuilding) return q.size();
        foreach (pend[i]) if (pend[i] < rb_cycles) n++;
        return n;
    endfunction

    always @(negedge CLK) begin
        if (mvalid) begin
            int e_halt;
            int e_data;
            e_halt = (rebuilding || q.size() == 0) ? 1 : 0;
            e_data = e_halt ? 0 : q[0];
            chk("model_count", int'(count), exp_count());
            chk("model_halt", int'(halt), e_halt);
            chk("model_deque_data", int'(deque_data), e_data);
            chk("model_overflow", int'(overflow_err), int'(movf));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < NUM_AREGS; a++) r_mapping[a] = '0;
        tick();
        do_reset();

        chk("reset_data", int'(deque_data), 32);
        chk("reset_count", int'(count), 32);
        chk("reset_halt", int'(halt), 0);
        chk("reset_ovf", int'(overflow_err), 0);

        // Drain all 32 reset tags.
        deque = 1'b1;
        for (int k = 0; k < 32; k++) begin
            chk("drain_data", int'(deque_data), 32 + k);
            tick();
        end
        chk("empty_count", int'(count), 0);
        chk("empty_halt", int'(halt), 1);
        chk("empty_data", int'(deque_data), 0);

        // Enqueue into an empty list with deque held high.
        enque = 1'b1;
        enque_data = tag_t'(5);
        tick();
        enque = 1'b0;
        chk("refill_count", int'(count), 1);
        chk("refill_data", int'(deque_data), 5);
        tick();
        deque = 1'b0;
        chk("refill_drained", int'(count), 0);

        // Simultaneous enqueue and dequeue at count 10.
        do_reset();
        deque = 1'b1;
        repeat (22) tick();
        chk("ten_count", int'(count), 10);
        chk("ten_head", int'(deque_data), 54);
        enque = 1'b1;
        enque_data = tag_t'(7);
        tick();
        chk("both_count", int'(count), 10);
        chk("both_head", int'(deque_data), 55);

        // Stall blocks only the dequeue.
        STALL = 1'b1;
        enque_data = tag_t'(9);
        tick();
        chk("stall_count", int'(count), 11);
        chk("stall_head", int'(deque_data), 55);
        STALL = 1'b0;
        enque = 1'b0;
        deque = 1'b1;
        repeat (9) tick();
        chk("tail_7", int'(deque_data), 7);
        tick();
        chk("tail_9", int'(deque_data), 9);
        deque = 1'b0;

        // Identity map flush: exactly 64 halt cycles.
        for (int a = 0; a < NUM_AREGS; a++) r_mapping[a] = tag_t'(a);
        FLUSH = 1'b1;
        enque = 1'b1;
        deque = 1'b1;
        tick();
        FLUSH = 1'b0;
        chk("flush_halt0", int'(halt), 1);
        for (int k = 0; k < 63; k++) begin
            tick();
            chk("flush_halt", int'(halt), 1);
        end
        enque = 1'b0;
        deque = 1'b0;
        tick();
        chk("rebuilt_halt", int'(halt), 0);
        chk("rebuilt_count", int'(count), 32);
        chk("rebuilt_data", int'(deque_data), 32);

        // Map with duplicates: tags 0..19 in use.
        for (int a = 0; a < NUM_AREGS; a++) r_mapping[a] = tag_t'((a * 3) % 20);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        repeat (64) tick();
        chk("dup_count", int'(count), 44);
        chk("dup_data", int'(deque_data), 20);
        deque = 1'b1;
        repeat (3) tick();
        deque = 1'b0;
        chk("dup_after3", int'(deque_data), 23);

        // Fill to capacity, then an extra enqueue overflows.
        do_reset();
        enque = 1'b1;
        for (int k = 0; k < 32; k++) begin
            enque_data = tag_t'(k);
            tick();
        end
        chk("full_count", int'(count), 64);
        chk("full_noovf", int'(overflow_err), 0);
        enque_data = tag_t'(63);
        tick();
        enque = 1'b0;
        chk("ovf_set", int'(overflow_err), 1);
        chk("ovf_count", int'(count), 64);

        // Flush, restart at idx 40, then reset mid-rebuild.
        for (int a = 0; a < NUM_AREGS; a++) r_mapping[a] = tag_t'(a);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        repeat (40) tick();
        for (int a = 0; a < NUM_AREGS; a++) r_mapping[a] = '0;
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        repeat (64) tick();
        chk("restart_count", int'(count), 63);
        chk("restart_data", int'(deque_data), 1);
        chk("ovf_sticky", int'(overflow_err), 1);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        repeat (40) tick();
        FLUSH = 1'b1;
        RESET = 1'b1;
        tick();
        FLUSH = 1'b0;
        RESET = 1'b0;
        chk("mid_reset_count", int'(count), 32);
        chk("mid_reset_data", int'(deque_data), 32);
        chk("mid_reset_halt", int'(halt), 0);
        chk("mid_reset_ovf", int'(overflow_err), 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
